// File: rtl/demux2x32_buf_pkg.sv
// Shared constants and types for the two-channel buffered demultiplexer.
// Depth and occupancy width are fixed by the 2-entry channel FIFOs.
package demux2x32_buf_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int FIFO_DEPTH    = 2;
  localparam int OCC_W         = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } fifo_state_e;

  // The state encoding is chosen so that it equals the occupancy count.
  function automatic logic [OCC_W-1:0] state_to_occ(input fifo_state_e st);
    return st;
  endfunction

endpackage

// File: rtl/demux2x32_buf_if.sv
// Source-side push bus plus both channel output buses of the demultiplexer.
// The source/sinks take the master modport, the block takes the slave modport.
interface demux2x32_buf_if
  import demux2x32_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic [WIDTH-1:0] D;
  logic             S;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] Y0;
  logic             Y0_VALID;
  logic             Y0_READY;
  logic [WIDTH-1:0] Y1;
  logic             Y1_VALID;
  logic             Y1_READY;
  logic [OCC_W-1:0] OCC0;
  logic [OCC_W-1:0] OCC1;

  modport master (
    output D, S, IN_VALID, Y0_READY, Y1_READY,
    input  IN_READY, Y0, Y0_VALID, Y1, Y1_VALID, OCC0, OCC1
  );

  modport slave (
    input  D, S, IN_VALID, Y0_READY, Y1_READY,
    output IN_READY, Y0, Y0_VALID, Y1, Y1_VALID, OCC0, OCC1
  );

endinterface

// File: rtl/demux_fifo2.sv
// Two-entry FIFO for one demux channel: 1-bit wrapping pointers, occupancy
// tracked as an EMPTY/ONE/FULL state, head word forced to zero when empty.
module demux_fifo2
  import demux2x32_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [OCC_W-1:0] occ_o
);

  fifo_state_e      state_q, state_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;
  logic [WIDTH-1:0] entry_rd [FIFO_DEPTH];

  // Guard against overflow/underflow even if the caller misbehaves.
  assign push_ok = push_i && (state_q != ST_FULL);
  assign pop_ok  = pop_i  && (state_q != ST_EMPTY);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q ^ push_ok;
    rd_ptr_d = rd_ptr_q ^ pop_ok;
    case (state_q)
      ST_EMPTY: if (push_ok) state_d = ST_ONE;
      ST_ONE: begin
        if (push_ok && !pop_ok)      state_d = ST_FULL;
        else if (pop_ok && !push_ok) state_d = ST_EMPTY;
      end
      ST_FULL:  if (pop_ok) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_q;

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          entry_q <= '0;
        end else if (push_ok && (wr_ptr_q == 1'(gi))) begin
          entry_q <= data_i;
        end
      end

      assign entry_rd[gi] = entry_q;
    end
  endgenerate

  assign valid_o = (state_q != ST_EMPTY);
  assign data_o  = valid_o ? entry_rd[rd_ptr_q] : '0;
  assign occ_o   = state_to_occ(state_q);

endmodule

// File: rtl/demux2x32_buf.sv
// Buffered 1-to-2 demultiplexer: steers each accepted word into the channel
// chosen by S; each channel drains independently through its own 2-entry FIFO.
module demux2x32_buf
  import demux2x32_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic              Clk,
  input  logic              Clrn,
  demux2x32_buf_if.slave    bus
);

  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       valid;
  logic [1:0]       sink_ready;
  logic [WIDTH-1:0] y_data [2];
  logic [OCC_W-1:0] occ    [2];
  logic [OCC_W-1:0] occ_sel;
  logic             in_ready;

  assign sink_ready = {bus.Y1_READY, bus.Y0_READY};

  // Acceptance looks only at the selected channel, so a stalled sibling never blocks.
  assign occ_sel  = bus.S ? occ[1] : occ[0];
  assign in_ready = (occ_sel < OCC_W'(FIFO_DEPTH));

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      assign push[gi] = bus.IN_VALID && in_ready && (bus.S == 1'(gi));
      assign pop[gi]  = valid[gi] && sink_ready[gi];

      demux_fifo2 #(
        .WIDTH (WIDTH)
      ) u_fifo (
        .clk_i   (Clk),
        .rst_n_i (Clrn),
        .push_i  (push[gi]),
        .pop_i   (pop[gi]),
        .data_i  (bus.D),
        .data_o  (y_data[gi]),
        .valid_o (valid[gi]),
        .occ_o   (occ[gi])
      );
    end
  endgenerate

  assign bus.IN_READY = in_ready;
  assign bus.Y0       = y_data[0];
  assign bus.Y0_VALID = valid[0];
  assign bus.OCC0     = occ[0];
  assign bus.Y1       = y_data[1];
  assign bus.Y1_VALID = valid[1];
  assign bus.OCC1     = occ[1];

endmodule

// File: tb/tb_demux2x32_buf.sv
// Scoreboard bench for demux2x32_buf: per-channel queues model the FIFOs,
// a separate monitor pops and compares every word the DUT hands to a sink.
module tb_demux2x32_buf;
  import demux2x32_buf_pkg::*;

  localparam int W = 32;

  logic clk  = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  demux2x32_buf_if #(.WIDTH(W)) bus ();

  demux2x32_buf #(.WIDTH(W)) dut (
    .Clk  (clk),
    .Clrn (clrn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  int cnt0 = 0;
  int cnt1 = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare the current DUT state with the model, then account for this cycle's inputs.
  task automatic model_cycle(input bit v, input bit s, input logic [W-1:0] d, input bit r0, input bit r1);
    int  occ_s;
    bit  pop0, pop1, push;
    check("occ0", W'(bus.OCC0), W'(cnt0));
    check("occ1", W'(bus.OCC1), W'(cnt1));
    check("y0_valid", W'(bus.Y0_VALID), W'(cnt0 > 0));
    check("y1_valid", W'(bus.Y1_VALID), W'(cnt1 > 0));
    check("y0_head", bus.Y0, (cnt0 > 0) ? q0[0] : '0);
    check("y1_head", bus.Y1, (cnt1 > 0) ? q1[0] : '0);
    occ_s = s ? cnt1 : cnt0;
    check("in_ready", W'(bus.IN_READY), W'(occ_s < 2));
    pop0 = (cnt0 > 0) && r0;
    pop1 = (cnt1 > 0) && r1;
    push = v && (occ_s < 2);
    if (push) begin
      if (s) q1.push_back(d);
      else   q0.push_back(d);
      $display("push ch%0d data %h", s, d);
    end
    cnt0 = cnt0 - int'(pop0) + int'(push && !s);
    cnt1 = cnt1 - int'(pop1) + int'(push && s);
  endtask

  task automatic step(input bit v, input bit s, input logic [W-1:0] d, input bit r0, input bit r1);
    @(posedge clk);
    #1;
    bus.IN_VALID = v;
    bus.S        = s;
    bus.D        = d;
    bus.Y0_READY = r0;
    bus.Y1_READY = r1;
    @(negedge clk);
    model_cycle(v, s, d, r0, r1);
  endtask

  // Clrn pulsed low mid-cycle; outputs must clear before the next rising edge.
  task automatic do_reset();
    @(posedge clk);
    #2;
    bus.IN_VALID = 1'b0;
    bus.Y0_READY = 1'b0;
    bus.Y1_READY = 1'b0;
    bus.S        = 1'b0;
    clrn         = 1'b0;
    #1;
    check("rst_occ0", W'(bus.OCC0), '0);
    check("rst_occ1", W'(bus.OCC1), '0);
    check("rst_y0_valid", W'(bus.Y0_VALID), '0);
    check("rst_y1_valid", W'(bus.Y1_VALID), '0);
    check("rst_y0", bus.Y0, '0);
    check("rst_y1", bus.Y1, '0);
    check("rst_in_ready_s0", W'(bus.IN_READY), W'(1));
    bus.S = 1'b1;
    #1;
    check("rst_in_ready_s1", W'(bus.IN_READY), W'(1));
    q0.delete();
    q1.delete();
    cnt0 = 0;
    cnt1 = 0;
    #3;
    clrn = 1'b1;
  endtask

  // Monitor: consumes a word whenever a sink handshake will complete at the next edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (bus.Y0_VALID === 1'b1 && bus.Y0_READY === 1'b1) begin
        if (q0.size() == 0) check("y0_pop_unexpected", W'(bus.Y0_VALID), '0);
        else begin
          $display("pop  ch0 data %h", bus.Y0);
          check("y0_pop_data", bus.Y0, q0.pop_front());
        end
      end
      if (bus.Y1_VALID === 1'b1 && bus.Y1_READY === 1'b1) begin
        if (q1.size() == 0) check("y1_pop_unexpected", W'(bus.Y1_VALID), '0);
        else begin
          $display("pop  ch1 data %h", bus.Y1);
          check("y1_pop_data", bus.Y1, q1.pop_front());
        end
      end
    end
  end

  initial begin
    bus.IN_VALID = 1'b0;
    bus.S        = 1'b0;
    bus.D        = '0;
    bus.Y0_READY = 1'b0;
    bus.Y1_READY = 1'b0;
    #23;
    clrn = 1'b1;

    // Reset behaviour from idle
    do_reset();
    step(0, 0, '0, 0, 0);

    // Routing
    step(1, 0, 32'h1111_1111, 0, 0);
    step(1, 1, 32'h2222_2222, 0, 0);
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 1, 1);
    step(0, 0, '0, 0, 0);

    // Full and backpressure
    do_reset();
    step(1, 0, 32'hAAAA_0001, 0, 0);
    step(1, 0, 32'hAAAA_0002, 0, 0);
    step(1, 0, 32'hAAAA_0003, 0, 0);
    step(0, 1, '0, 0, 0);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 0, 0);

    // Order and wrap with the sink always ready
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 0, 32'hF000_00A0 + W'(i), 1, 0);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 0, 0);

    // Simultaneous push/pop at OCC=1 and at OCC=2
    do_reset();
    step(1, 0, 32'h0000_00C1, 0, 0);
    step(1, 0, 32'h0000_00C2, 1, 0);
    step(1, 0, 32'h0000_00C3, 0, 0);
    step(1, 0, 32'h0000_00C4, 1, 0);
    step(0, 0, '0, 0, 0);

    // Reset mid-operation, then restart from EMPTY
    do_reset();
    step(1, 0, 32'h5555_0001, 0, 0);
    step(1, 0, 32'h5555_0002, 0, 0);
    step(1, 1, 32'h5555_0003, 0, 0);
    step(0, 0, '0, 0, 0);
    do_reset();
    step(1, 1, 32'hDEAD_BEEF, 0, 0);
    step(0, 1, '0, 0, 0);
    step(0, 0, '0, 0, 1);

    // Randomised traffic with an occasional reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)), W'($urandom),
           bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 4; i++) step(0, 0, '0, 1, 1);
    step(0, 0, '0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
